ysyx_22040125_mem_arb: RTL
==========================

# ysyx_22040125_mem_arb

Single-owner arbiter sharing the core's unified single-port instruction/data memory between the instruction-fetch unit (IF) and the load/store unit (LSU). Accepts one request at a time from either requester over a valid/ready handshake and forwards it to the memory port. Tracks the single outstanding transaction and routes the memory response back to the requester that issued it. Sits between the IF/LSU stages and the memory model.

## Interface
- ADDR_W, 32, request address width
- DATA_W, 64, data width; byte-mask width is DATA_W/8
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- if_req_valid  in  1  IF request present; read-only
- if_req_ready  out  1  IF request accepted this cycle
- if_req_addr  in  ADDR_W  IF fetch address
- if_resp_valid  out  1  IF response strobe, one cycle
- if_resp_rdata  out  DATA_W  IF read data
- lsu_req_valid  in  1  LSU request present
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  ADDR_W  LSU address
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_wdata  in  DATA_W  store data
- lsu_req_wmask  in  DATA_W/8  store byte enables
- lsu_resp_valid  out  1  LSU response strobe; fires for loads and stores
- lsu_resp_rdata  out  DATA_W  LSU load data; 0 for stores
- mem_valid  out  1  memory request issue, one cycle per transaction
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  memory request fields
- mem_rvalid  in  1  memory completion, at least 1 cycle after mem_valid
- mem_rdata  in  DATA_W  memory read data, valid with mem_rvalid

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_LSU.
- IDLE:
  - Picks a winner among the valid requesters.
  - Asserts that requester's ready combinationally in the same cycle.
  - Drives mem_valid and the request fields from the winner's inputs in the same cycle.
  - Next state is BUSY_IF or BUSY_LSU.
- BUSY_x:
  - All readys are 0 and mem_valid is 0.
  - On mem_rvalid, x_resp_valid = 1 and x_resp_rdata = mem_rdata in the same cycle; next state is IDLE.
  - For an LSU store, lsu_resp_rdata = 0.
- IF requests always drive mem_wen = 0 and mem_wmask = 0.
- Requester rule: valid must hold, with stable fields, until ready. The arbiter does not latch unaccepted requests.
- mem_rvalid in IDLE is a stray completion: ignored, with no resp strobe.
- Owner register last_lsu records the owner of the most recent grant. Reset value 0.
- Resp outputs for the non-owner are 0. rdata outputs are 0 whenever their resp_valid is 0.

## Timing
- Reset (rst = 0 at posedge):
  - State returns to IDLE and last_lsu = 0.
  - All ready, resp_valid and mem_valid outputs read 0 while rst = 0.
  - An in-flight transaction is abandoned; its late mem_rvalid is ignored as a stray.
- Issue latency: 0 cycles from a valid request in IDLE to mem_valid.
- Response latency: equals the memory latency, with 0 added cycles.
- Throughput: next issue is possible the cycle after mem_rvalid. With 1-cycle memory, that is one transaction per 2 cycles.
- A new request arriving in the same cycle as mem_rvalid is not accepted until the following IDLE cycle.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - When both requesters are valid in IDLE, the grant goes to the requester that is not last_lsu's owner.
  - A single valid requester always wins.
- ARB_RR_EN undefined: fixed priority, LSU over IF.
  - last_lsu is still maintained but does not affect the grant.

## Structure
- Package ysyx_22040125_arb_pkg holds:
  - the state enum (IDLE, BUSY_IF, BUSY_LSU);
  - owner encoding constants OWN_IF = 0, OWN_LSU = 1.
- Sub-module ysyx_22040125_arb_pick is purely combinational:
  - inputs: if_valid, lsu_valid, last_lsu;
  - outputs: grant_if, grant_lsu;
  - it contains the ARB_RR_EN selection.
- The top holds the FSM, the owner register and the mux/demux of request and response fields.

## Test plan
- Reset then idle -> all readys and strobes 0; mem_rvalid pulse produces no resp strobe.
- IF alone, addr 0x80000000, memory returns 0x00000013_00000093 after 1 cycle:
  - if_req_ready and mem_valid in cycle 0;
  - if_resp_valid with that data in cycle 1;
  - next issue in cycle 2.
- LSU store, addr 0x80001008, wdata 0xDEADBEEF_CAFEF00D, wmask 0xF0, 3-cycle memory:
  - mem fields match the request;
  - lsu_resp_valid in cycle 3 with rdata 0;
  - IF stays unready during cycles 0–2.
- Both valid continuously, 1-cycle memory:
  - with ARB_RR_EN, grants alternate LSU, IF, LSU, IF;
  - without ARB_RR_EN, LSU takes every grant and IF starves.
- Reset asserted in BUSY_LSU before mem_rvalid:
  - the arbiter returns to IDLE;
  - the late mem_rvalid gives no lsu_resp_valid;
  - a subsequent IF request issues normally.

Source files
------------

// File: rtl/ysyx_22040125_arb_pkg.sv
// Shared types and owner encodings for the IF/LSU memory arbiter.
package ysyx_22040125_arb_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusyIf  = 2'd1,
    StBusyLsu = 2'd2
  } state_e;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_22040125_mem_arb_if.sv
// Bundle of IF, LSU and memory-port signals around the arbiter.
// slave: the arbiter's view; master: requesters plus memory model.
interface ysyx_22040125_mem_arb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);

  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [ADDR_W-1:0]     if_req_addr;
  logic                  if_resp_valid;
  logic [DATA_W-1:0]     if_resp_rdata;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_W-1:0]     lsu_req_addr;
  logic                  lsu_req_wen;
  logic [DATA_W-1:0]     lsu_req_wdata;
  logic [DATA_W/8-1:0]   lsu_req_wmask;
  logic                  lsu_resp_valid;
  logic [DATA_W-1:0]     lsu_resp_rdata;

  logic                  mem_valid;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wen;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_rdata,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
    output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_rvalid, mem_rdata
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_rdata,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
    input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/ysyx_22040125_arb_pick.sv
// Combinational winner selection between IF and LSU.
// Macro ARB_RR_EN: round-robin on contention; otherwise fixed LSU-over-IF priority.
module ysyx_22040125_arb_pick
  import ysyx_22040125_arb_pkg::*;
(
  input  logic if_valid,
  input  logic lsu_valid,
  input  logic last_lsu,
  output logic grant_if,
  output logic grant_lsu
);

`ifndef ARB_RR_EN
  logic unused_last_lsu;
  assign unused_last_lsu = last_lsu;
`endif

  always_comb begin
    grant_if  = 1'b0;
    grant_lsu = 1'b0;
    if (if_valid && lsu_valid) begin
`ifdef ARB_RR_EN
      // Contention goes to whoever did not own the previous grant.
      grant_lsu = (last_lsu == OWN_IF);
`else
      grant_lsu = 1'b1;
`endif
      grant_if = !grant_lsu;
    end else begin
      grant_if  = if_valid;
      grant_lsu = lsu_valid;
    end
  end

endmodule

// File: rtl/ysyx_22040125_mem_arb.sv
// Single-owner arbiter sharing one memory port between IF and LSU.
// Optional macro ARB_RR_EN (in the picker) selects round-robin arbitration.
module ysyx_22040125_mem_arb
  import ysyx_22040125_arb_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  ysyx_22040125_mem_arb_if.slave bus
);

  state_e state_q, state_d;
  logic   last_lsu_q, last_lsu_d;
  logic   store_q, store_d;
  logic   grant_if, grant_lsu;

  ysyx_22040125_arb_pick u_pick (
    .if_valid  (bus.if_req_valid),
    .lsu_valid (bus.lsu_req_valid),
    .last_lsu  (last_lsu_q),
    .grant_if  (grant_if),
    .grant_lsu (grant_lsu)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      last_lsu_q <= OWN_IF;
      store_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_lsu_q <= last_lsu_d;
      store_q    <= store_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    last_lsu_d         = last_lsu_q;
    store_d            = store_q;
    bus.if_req_ready   = 1'b0;
    bus.if_resp_valid  = 1'b0;
    bus.if_resp_rdata  = '0;
    bus.lsu_req_ready  = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    bus.lsu_resp_rdata = '0;
    bus.mem_valid      = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_wen        = 1'b0;
    bus.mem_wdata      = '0;
    bus.mem_wmask      = '0;

    // Everything stays quiet while reset is held.
    if (rst) begin
      unique case (state_q)
        StIdle: begin
          // mem_rvalid here is a stray completion and is deliberately ignored.
          if (grant_lsu) begin
            bus.lsu_req_ready = 1'b1;
            bus.mem_valid     = 1'b1;
            bus.mem_addr      = bus.lsu_req_addr;
            bus.mem_wen       = bus.lsu_req_wen;
            bus.mem_wdata     = bus.lsu_req_wdata;
            bus.mem_wmask     = bus.lsu_req_wmask;
            store_d           = bus.lsu_req_wen;
            last_lsu_d        = OWN_LSU;
            state_d           = StBusyLsu;
          end else if (grant_if) begin
            bus.if_req_ready = 1'b1;
            bus.mem_valid    = 1'b1;
            bus.mem_addr     = bus.if_req_addr;
            last_lsu_d       = OWN_IF;
            state_d          = StBusyIf;
          end
        end
        StBusyIf: begin
          if (bus.mem_rvalid) begin
            bus.if_resp_valid = 1'b1;
            bus.if_resp_rdata = bus.mem_rdata;
            state_d           = StIdle;
          end
        end
        StBusyLsu: begin
          if (bus.mem_rvalid) begin
            bus.lsu_resp_valid = 1'b1;
            bus.lsu_resp_rdata = store_q ? '0 : bus.mem_rdata;
            state_d            = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

endmodule
